// File: rtl/text_console.sv
// Character-mode console: 12x4 glyph buffer fed by host byte commands, plus a
// fixed two-cycle pixel pipeline through an external registered font ROM.
module text_console #(
    parameter int unsigned COLS       = 12,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned BLINK_BITS = 22,
    parameter logic [7:0]  FG         = 8'hff,
    parameter logic [7:0]  BG         = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [5:0]  y,
    output logic [7:0]  color,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic [3:0]  cursor_col,
    output logic [1:0]  cursor_row
);
    localparam int unsigned NCELLS   = COLS * ROWS;
    localparam logic [7:0]  SPACE    = 8'h20;
    localparam logic [5:0]  LAST     = 6'(NCELLS - 1);
    localparam logic [5:0]  COPY_END = 6'(NCELLS - COLS);
    localparam logic [3:0]  LASTCOL  = 4'(COLS - 1);
    localparam logic [1:0]  LASTROW  = 2'(ROWS - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL} state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [3:0]            col_q, col_d;
    logic [1:0]            row_q, row_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [7:0]            buf_q [NCELLS];
    logic [7:0]            buf_d [NCELLS];

    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] cursor_idx;
    logic [5:0] src_idx;

    logic [3:0] pcol;
    logic [1:0] prow;
    logic [5:0] ridx;
    logic       blank_s0;
    logic       inv_s0;

    logic [7:0] char_q, char_d;
    logic [3:0] grow_q, grow_d;
    logic [2:0] bit1_q, bit1_d;
    logic       blank1_q, blank1_d;
    logic       inv1_q, inv1_d;
    logic [2:0] bit2_q, bit2_d;
    logic       blank2_q, blank2_d;
    logic       inv2_q, inv2_d;
    logic       pix;

    // Display pipeline: address stage, then ROM data stage.
    always_comb begin
        pcol     = x[6:3];
        prow     = y[5:4];
        blank_s0 = (x >= 8'(COLS * 8)) || ({1'b0, y} >= 7'(ROWS * 16));
        ridx     = blank_s0 ? '0 : 6'(32'(prow) * COLS + 32'(pcol));
        inv_s0   = (pcol == col_q) && (prow == row_q) && blink_q[BLINK_BITS-1];

        char_d   = buf_q[ridx];
        grow_d   = y[3:0];
        bit1_d   = x[2:0];
        blank1_d = blank_s0;
        inv1_d   = inv_s0;

        bit2_d   = bit1_q;
        blank2_d = blank1_q;
        inv2_d   = inv1_q;

        font_addr = {char_q, grow_q};
        pix       = font_data[~bit2_q] ^ inv2_q;
        color     = (blank2_q || !pix) ? BG : FG;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        blink_d    = blink_q + BLINK_BITS'(1);
        wr_en      = 1'b0;
        wr_addr    = cnt_q;
        wr_data    = SPACE;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        cursor_idx = 6'(32'(row_q) * COLS + 32'(col_q));
        src_idx    = 6'(32'(cnt_q) + COLS);

        case (state_q)
            S_CLEAR: begin
                wr_en = 1'b1;
                col_d = '0;
                row_d = '0;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_data >= 8'h20 && cmd_data <= 8'h7e) begin
                        wr_en   = 1'b1;
                        wr_addr = cursor_idx;
                        wr_data = cmd_data;
                        if (col_q == LASTCOL) begin
                            col_d = '0;
                            if (row_q == LASTROW) begin
                                state_d = S_SCROLL;
                                cnt_d   = '0;
                            end else begin
                                row_d = row_q + 2'd1;
                            end
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        case (cmd_data)
                            8'h0a: begin
                                col_d = '0;
                                if (row_q == LASTROW) begin
                                    state_d = S_SCROLL;
                                    cnt_d   = '0;
                                end else begin
                                    row_d = row_q + 2'd1;
                                end
                            end
                            8'h0d: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - 4'd1;
                                    wr_en   = 1'b1;
                                    wr_addr = cursor_idx - 6'd1;
                                end
                            end
                            8'h0c: begin
                                state_d = S_CLEAR;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_SCROLL: begin
                wr_en = 1'b1;
                col_d = '0;
                row_d = LASTROW;
                if (cnt_q < COPY_END) wr_data = buf_q[src_idx];
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (wr_en) buf_d[wr_addr] = wr_data;
    end

    // Buffer needs no reset: CLEAR always sweeps it after reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (reset) begin
            state_q  <= S_CLEAR;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            blink_q  <= '0;
            char_q   <= '0;
            grow_q   <= '0;
            bit1_q   <= '0;
            blank1_q <= 1'b1;
            inv1_q   <= 1'b0;
            bit2_q   <= '0;
            blank2_q <= 1'b1;
            inv2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blink_q  <= blink_d;
            char_q   <= char_d;
            grow_q   <= grow_d;
            bit1_q   <= bit1_d;
            blank1_q <= blank1_d;
            inv1_q   <= inv1_d;
            bit2_q   <= bit2_d;
            blank2_q <= blank2_d;
            inv2_q   <= inv2_d;
        end
    end

    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a behavioural registered font ROM;
// buffer contents are observed through the display pipeline's font_addr.
module tb_text_console;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x = '0;
    logic [5:0]  y = '0;
    logic [7:0]  color;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = '0;
    logic        cmd_ready;
    logic        busy;
    logic [3:0]  cursor_col;
    logic [1:0]  cursor_row;

    int tests = 0;
    int fails = 0;
    logic [3:0] tb_blink = '0;

    text_console #(.BLINK_BITS(4)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .color(color),
        .font_addr(font_addr), .font_data(font_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        if (a[11:4] == 8'h20) return 8'h00;
        return a[11:4] ^ {a[3:0], ~a[3:0]};
    endfunction

    always @(posedge clk) font_data <= rom_fn(font_addr);
    always @(posedge clk) tb_blink <= reset ? 4'd0 : tb_blink + 4'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(n), 32'd0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic read_cell(input int idx, output logic [7:0] c);
        x = 8'((idx % 12) * 8);
        y = 6'((idx / 12) * 16);
        tick();
        c = font_addr[11:4];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] c;
        logic [7:0] r;
        logic [7:0] e;

        // Reset state
        tick();
        check("rst_color", color, 8'h00);
        check("rst_busy", busy, 1);
        check("rst_ready", cmd_ready, 0);
        check("rst_ccol", cursor_col, 0);
        check("rst_crow", cursor_row, 0);
        tick();
        tick();
        reset = 1'b0;
        wait_idle(n);
        check("clear_len", n, 48);
        check("clear_ready", cmd_ready, 1);
        for (int i = 0; i < 48; i++) begin
            read_cell(i, c);
            check("clear_cell", c, 8'h20);
        end

        // Cursor blink at (0,0) over both blink phases
        for (int i = 0; i < 16; i++) begin
            x = 8'd3;
            y = 6'd5;
            e = tb_blink[3] ? 8'hff : 8'h00;
            tick();
            tick();
            check("blink_cursor", color, e);
        end
        x = 8'd8; y = 6'd5;
        tick(); tick();
        check("noncursor_bg", color, 8'h00);
        x = 8'd100; y = 6'd5;
        tick(); tick();
        check("oob_bg", color, 8'h00);

        // Latency: 'M' at (0,0), stream pixels of that cell
        send(8'h4D);
        check("m_ccol", cursor_col, 1);
        for (int k = 0; k <= 128; k++) begin
            if (k < 128) begin
                x = 8'(k % 8);
                y = 6'(k / 8);
            end
            tick();
            if (k < 128) check("lat_addr", font_addr, {8'h4D, 4'(k / 8)});
            if (k >= 1) begin
                r = rom_fn({8'h4D, 4'((k - 1) / 8)});
                check("lat_color", color, r[7 - ((k - 1) % 8)] ? 8'hff : 8'h00);
            end
        end

        // Control codes
        send(8'h0C);
        wait_idle(n);
        check("ff_len", n, 48);
        send(8'h41);
        send(8'h42);
        send(8'h08);
        check("bs1_ccol", cursor_col, 1);
        read_cell(1, c);
        check("bs1_cell1", c, 8'h20);
        read_cell(0, c);
        check("bs1_cell0", c, 8'h41);
        send(8'h08);
        check("bs2_ccol", cursor_col, 0);
        read_cell(0, c);
        check("bs2_cell0", c, 8'h20);
        send(8'h08);
        check("bs3_ccol", cursor_col, 0);
        check("bs3_crow", cursor_row, 0);
        check("bs3_busy", busy, 0);
        send(8'h0D);
        send(8'h0A);
        check("crlf_ccol", cursor_col, 0);
        check("crlf_crow", cursor_row, 1);

        // Backpressure through a form feed
        cmd_valid = 1'b1;
        cmd_data  = 8'h0C;
        tick();
        cmd_data = 8'h51;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("bp_wait", n, 48);
        tick();
        cmd_data = 8'h52;
        tick();
        cmd_valid = 1'b0;
        check("bp_ccol", cursor_col, 2);
        check("bp_crow", cursor_row, 0);
        read_cell(0, c);
        check("bp_cell0", c, 8'h51);
        read_cell(1, c);
        check("bp_cell1", c, 8'h52);
        read_cell(2, c);
        check("bp_cell2", c, 8'h20);

        // Wrap and scroll
        send(8'h0C);
        wait_idle(n);
        for (int i = 0; i < 47; i++) send(8'(8'h41 + i));
        check("pre_ccol", cursor_col, 11);
        check("pre_crow", cursor_row, 3);
        send(8'h70);
        check("scr_busy", busy, 1);
        check("scr_ready", cmd_ready, 0);
        wait_idle(n);
        check("scr_len", n, 48);
        check("scr_ccol", cursor_col, 0);
        check("scr_crow", cursor_row, 3);
        for (int i = 0; i < 48; i++) begin
            read_cell(i, c);
            check("scr_cell", c, (i < 36) ? 32'(8'h41 + i + 12) : 32'h20);
        end

        // Reset in the middle of a scroll
        for (int i = 0; i < 12; i++) send(8'(8'h61 + i));
        check("scr2_busy", busy, 1);
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busy", busy, 1);
        check("mr_ccol", cursor_col, 0);
        check("mr_crow", cursor_row, 0);
        wait_idle(n);
        check("mr_len", n, 48);
        for (int i = 0; i < 48; i++) begin
            read_cell(i, c);
            check("mr_cell", c, 8'h20);
        end
        check("mr_ccol2", cursor_col, 0);
        check("mr_crow2", cursor_row, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
